ise_image_feeder: RTL and testbench

Transmit side of the image-sorting-engine pixel interface. Reads every image from an external pixel memory with fixed 1-cycle read latency and streams it into the engine's `image_in_index`/`pixel_in` port. It respects the engine's `busy` back-pressure and owns the engine's reset, so the first pixel is ready the moment the engine leaves reset. It sits between the pixel SRAM/ROM and the sorting engine in the top-level integration.

---
 rtl/ise_pkg.sv | 21 ++
 rtl/ise_feed_fifo.sv | 51 +++++
 rtl/ise_image_feeder.sv | 105 ++++++++++
 tb/tb_ise_image_feeder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ise_pkg.sv
// Shared types and sizing for the image-sorting-engine pixel interface.
package ise_pkg;

  localparam int unsigned PIXEL_W        = 24;
  localparam int unsigned IMG_IDX_W      = 5;
  localparam int unsigned ISE_NUM_IMAGES = 32;
  localparam int unsigned ISE_PIXELS     = 16384;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM,
    DONE
  } feed_state_t;

  typedef struct packed {
    logic [IMG_IDX_W-1:0] img;
    logic [PIXEL_W-1:0]   pix;
  } feed_entry_t;

endpackage

// File: rtl/ise_feed_fifo.sv
// Prefetch FIFO of {image index, pixel} entries with a registered head that
// holds its last value while the FIFO is empty.
module ise_feed_fifo
  import ise_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  feed_entry_t      wdata,
  input  logic             pop,
  output feed_entry_t      head,
  output logic [CNT_W-1:0] count
);

  feed_entry_t      store [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= wdata;
  end

  // Head tracks the entry that will be at the front after this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (pop) begin
        if (count > CNT_W'(1)) head <= store[ptr_inc(rd_ptr)];
        else if (push)         head <= wdata;
      end else if ((count == '0) && push) begin
        head <= wdata;
      end
    end
  end

endmodule

// File: rtl/ise_image_feeder.sv
// Streams every image from a 1-cycle-latency pixel memory into the sorting
// engine, honouring busy back-pressure and owning the engine reset.
module ise_image_feeder
  import ise_pkg::*;
#(
  parameter int unsigned NUM_IMAGES = ISE_NUM_IMAGES,
  parameter int unsigned PIXELS     = ISE_PIXELS,
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned ADDR_W    = $clog2(NUM_IMAGES * PIXELS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 busy,
  output logic                 mem_rd,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [PIXEL_W-1:0]   mem_rdata,
  output logic                 ise_rst,
  output logic [IMG_IDX_W-1:0] image_in_index,
  output logic [PIXEL_W-1:0]   pixel_in,
  output logic                 feed_done,
  output logic                 underflow
);

  localparam int unsigned TOTAL    = NUM_IMAGES * PIXELS;
  localparam int unsigned CNT_W    = ADDR_W + 1;
  localparam int unsigned PIX_BITS = $clog2(PIXELS);
  localparam int unsigned FCNT_W   = $clog2(FIFO_DEPTH + 1);

  feed_state_t       state, next_state;
  logic [CNT_W-1:0]  rd_cnt, cons_cnt;
  logic [FCNT_W-1:0] fifo_count;
  logic [FCNT_W:0]   occ_c;
  logic              pop_c, issue_c, underflow_c, restart_c;
  feed_entry_t       push_entry, head;

  assign push_entry.img = IMG_IDX_W'(mem_addr >> PIX_BITS);
  assign push_entry.pix = mem_rdata;
  assign image_in_index = head.img;
  assign pixel_in       = head.pix;

  // mem_rd doubles as the in-flight flag: its data lands at the next edge.
  always_comb begin
    next_state  = state;
    pop_c       = 1'b0;
    issue_c     = 1'b0;
    underflow_c = 1'b0;
    restart_c   = 1'b0;
    occ_c       = '0;
    if (state == STREAM && !busy) begin
      pop_c       = (fifo_count != '0);
      underflow_c = (fifo_count == '0) && (cons_cnt < CNT_W'(TOTAL));
    end
    occ_c = (FCNT_W + 1)'(fifo_count) + (FCNT_W + 1)'(mem_rd) - (FCNT_W + 1)'(pop_c);
    if (state == PRIME || state == STREAM)
      issue_c = (occ_c < (FCNT_W + 1)'(FIFO_DEPTH)) && (rd_cnt < CNT_W'(TOTAL));
    case (state)
      IDLE:    if (start) begin next_state = PRIME; restart_c = 1'b1; end
      PRIME:   if (fifo_count == FCNT_W'(FIFO_DEPTH)) next_state = STREAM;
      STREAM:  if (cons_cnt == CNT_W'(TOTAL)) next_state = DONE;
      DONE:    if (start) begin next_state = PRIME; restart_c = 1'b1; end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rd_cnt    <= '0;
      cons_cnt  <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      ise_rst   <= 1'b1;
      feed_done <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= next_state;
      mem_rd    <= issue_c;
      ise_rst   <= (next_state == IDLE) || (next_state == PRIME);
      feed_done <= (next_state == DONE);
      underflow <= underflow | underflow_c;
      if (restart_c) begin
        rd_cnt   <= '0;
        cons_cnt <= '0;
      end else begin
        if (issue_c) begin
          mem_addr <= rd_cnt[ADDR_W-1:0];
          rd_cnt   <= rd_cnt + CNT_W'(1);
        end
        if (pop_c) cons_cnt <= cons_cnt + CNT_W'(1);
      end
    end
  end

  ise_feed_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (mem_rd),
    .wdata (push_entry),
    .pop   (pop_c),
    .head  (head),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_ise_image_feeder.sv
// Directed bench for ise_image_feeder with a small 2x4 image set.
module tb_ise_image_feeder;
  import ise_pkg::*;

  localparam int unsigned NI = 2;
  localparam int unsigned PX = 4;
  localparam int unsigned FD = 2;

  logic                 clk = 1'b0;
  logic                 reset, start, busy;
  logic                 mem_rd;
  logic [2:0]           mem_addr;
  logic [PIXEL_W-1:0]   mem_rdata;
  logic                 ise_rst;
  logic [IMG_IDX_W-1:0] image_in_index;
  logic [PIXEL_W-1:0]   pixel_in;
  logic                 feed_done;
  logic                 underflow;

  int checks   = 0;
  int failures = 0;
  int k;

  always #5 clk = ~clk;

  // Memory word equals its address; a marker value when no read is active.
  assign mem_rdata = mem_rd ? 24'(mem_addr) : 24'hDEAD00;

  ise_image_feeder #(.NUM_IMAGES(NI), .PIXELS(PX), .FIFO_DEPTH(FD)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .busy           (busy),
    .mem_rd         (mem_rd),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .ise_rst        (ise_rst),
    .image_in_index (image_in_index),
    .pixel_in       (pixel_in),
    .feed_done      (feed_done),
    .underflow      (underflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ise_rst"}, 32'(ise_rst), 32'd1);
    check({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_img"}, 32'(image_in_index), 32'd0);
    check({tag, "_pix"}, 32'(pixel_in), 32'd0);
    check({tag, "_done"}, 32'(feed_done), 32'd0);
    check({tag, "_uflow"}, 32'(underflow), 32'd0);
  endtask

  // Start pulse through to ise_rst low; busy held high while priming.
  task automatic prime_run(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_rst_t"}, 32'(ise_rst), 32'd1);
    step();
    check({tag, "_rd_t1"}, 32'(mem_rd), 32'd1);
    check({tag, "_addr_t1"}, 32'(mem_addr), 32'd0);
    step();
    check({tag, "_addr_t2"}, 32'(mem_addr), 32'd1);
    check({tag, "_head_t2"}, 32'(pixel_in), 32'd0);
    step();
    check({tag, "_rd_t3"}, 32'(mem_rd), 32'd0);
    check({tag, "_rst_t3"}, 32'(ise_rst), 32'd1);
    step();
    check({tag, "_rst_t4"}, 32'(ise_rst), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 6 && !feed_done; c++) step();
    check({tag, "_feed_done"}, 32'(feed_done), 32'd1);
    check({tag, "_ise_rst_done"}, 32'(ise_rst), 32'd0);
    check({tag, "_uflow"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    busy  = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    check_reset_values("por");
    step();
    check("idle_rst", 32'(ise_rst), 32'd1);
    check("idle_no_rd", 32'(mem_rd), 32'd0);

    // Basic stream: one pixel per cycle, no bubbles.
    prime_run("basic");
    busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("basic_pix", 32'(pixel_in), 32'(i));
      check("basic_img", 32'(image_in_index), 32'(i / 4));
      step();
    end
    check("basic_done_not_yet", 32'(feed_done), 32'd0);
    step();
    check("basic_feed_done", 32'(feed_done), 32'd1);
    check("basic_rst_low_done", 32'(ise_rst), 32'd0);
    check("basic_hold_pix", 32'(pixel_in), 32'd7);
    check("basic_uflow", 32'(underflow), 32'd0);
    step();
    check("basic_done_no_rd", 32'(mem_rd), 32'd0);

    // Restart from DONE followed by an inter-image gap.
    busy  = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_rst", 32'(ise_rst), 32'd1);
    check("restart_done_clr", 32'(feed_done), 32'd0);
    step();
    check("restart_addr0", 32'(mem_addr), 32'd0);
    check("restart_rd", 32'(mem_rd), 32'd1);
    step();
    step();
    step();
    check("gap_rst_low", 32'(ise_rst), 32'd0);
    busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("gap_pix_a", 32'(pixel_in), 32'(i));
      step();
    end
    busy = 1'b1;
    repeat (22) step();
    check("gap_rd_stopped", 32'(mem_rd), 32'd0);
    check("gap_head_pix", 32'(pixel_in), 32'd4);
    check("gap_head_img", 32'(image_in_index), 32'd1);
    busy = 1'b0;
    for (int i = 4; i < 8; i++) begin
      check("gap_pix_b", 32'(pixel_in), 32'(i));
      step();
    end
    wait_done("gap");

    // Alternating busy with a stray start pulse mid-stream.
    busy = 1'b1;
    prime_run("alt");
    k = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      busy  = c[0];
      start = (c == 3);
      if (!busy) begin
        check("alt_pix", 32'(pixel_in), 32'(k));
        k++;
      end
      step();
    end
    start = 1'b0;
    busy  = 1'b0;
    check("alt_all_consumed", 32'(k), 32'd8);
    wait_done("alt");

    // Reset in the middle of a stream, then a clean restart.
    busy = 1'b1;
    prime_run("mid");
    busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mid_pix", 32'(pixel_in), 32'(i));
      step();
    end
    busy  = 1'b1;
    reset = 1'b1;
    step();
    check_reset_values("midrst");
    reset = 1'b0;
    step();
    prime_run("after_rst");
    busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("after_rst_pix", 32'(pixel_in), 32'(i));
      step();
    end
    wait_done("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
